// File: rtl/dtree_pkg.sv
// dtree_pkg: shared types and helpers for the sequential decision-tree evaluator.
//   - state_t   : walk FSM encoding (IDLE, WALK, DONE)
//   - *_f       : node-word width and field-offset functions of the block parameters
//   - node_t    : node word at the default parameter set, with a builder for benches
// Node word layout, MSB to LSB: leaf | fidx | shift | thresh | left | right.
package dtree_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int node_w_f(input int n_feat, input int feat_w, input int n_nodes);
      return 32'd1 + $clog2(n_feat) + $clog2(feat_w) + feat_w + 32'd2 * $clog2(n_nodes);
   endfunction

   function automatic int right_lsb_f();
      return 32'd0;
   endfunction

   function automatic int left_lsb_f(input int n_nodes);
      return $clog2(n_nodes);
   endfunction

   function automatic int thresh_lsb_f(input int n_nodes);
      return 32'd2 * $clog2(n_nodes);
   endfunction

   function automatic int shift_lsb_f(input int feat_w, input int n_nodes);
      return thresh_lsb_f(n_nodes) + feat_w;
   endfunction

   function automatic int fidx_lsb_f(input int feat_w, input int n_nodes);
      return shift_lsb_f(feat_w, n_nodes) + $clog2(feat_w);
   endfunction

   function automatic int leaf_bit_f(input int n_feat, input int feat_w, input int n_nodes);
      return fidx_lsb_f(feat_w, n_nodes) + $clog2(n_feat);
   endfunction

   localparam int DEF_N_FEAT  = 5;
   localparam int DEF_FEAT_W  = 8;
   localparam int DEF_N_NODES = 16;
   localparam int DEF_FIDX_W  = $clog2(DEF_N_FEAT);
   localparam int DEF_SH_W    = $clog2(DEF_FEAT_W);
   localparam int DEF_NIDX_W  = $clog2(DEF_N_NODES);

   typedef struct packed {
      logic                  leaf;
      logic [DEF_FIDX_W-1:0] fidx;
      logic [DEF_SH_W-1:0]   shift;
      logic [DEF_FEAT_W-1:0] thresh;
      logic [DEF_NIDX_W-1:0] left;
      logic [DEF_NIDX_W-1:0] right;
   } node_t;

   function automatic node_t make_node(input logic                  leaf,
                                       input logic [DEF_FIDX_W-1:0] fidx,
                                       input logic [DEF_SH_W-1:0]   shift,
                                       input logic [DEF_FEAT_W-1:0] thresh,
                                       input logic [DEF_NIDX_W-1:0] left,
                                       input logic [DEF_NIDX_W-1:0] right);
      node_t n;
      n.leaf   = leaf;
      n.fidx   = fidx;
      n.shift  = shift;
      n.thresh = thresh;
      n.left   = left;
      n.right  = right;
      return n;
   endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// dtree_node_cmp: combinational evaluation of one node word against the feature register.
// Ports:
//   feat     in  N_FEAT*FEAT_W  registered feature vector, feature 0 in the LSBs
//   node     in  NODE_W         node word being evaluated
//   is_leaf  out 1              node is a leaf
//   nxt      out NIDX_W         chosen child (left when the test holds, else right)
//   cls      out CLASS_W        leaf class (low bits of thresh)
//   err      out 1              internal node names a feature index >= N_FEAT
//   go_right out 1              right branch chosen (only with DTREE_PATH_EN)
module dtree_node_cmp
   import dtree_pkg::*;
#(
   parameter int N_FEAT  = 5,
   parameter int FEAT_W  = 8,
   parameter int CLASS_W = 5,
   parameter int N_NODES = 16,
   localparam int NIDX_W = $clog2(N_NODES),
   localparam int FIDX_W = $clog2(N_FEAT),
   localparam int SH_W   = $clog2(FEAT_W),
   localparam int NODE_W = node_w_f(N_FEAT, FEAT_W, N_NODES)
) (
   input  logic [N_FEAT*FEAT_W-1:0] feat,
   input  logic [NODE_W-1:0]        node,
   output logic                     is_leaf,
   output logic [NIDX_W-1:0]        nxt,
   output logic [CLASS_W-1:0]       cls,
`ifdef DTREE_PATH_EN
   output logic                     go_right,
`endif
   output logic                     err
);

   localparam int LEFT_LSB   = left_lsb_f(N_NODES);
   localparam int THRESH_LSB = thresh_lsb_f(N_NODES);
   localparam int SHIFT_LSB  = shift_lsb_f(FEAT_W, N_NODES);
   localparam int FIDX_LSB   = fidx_lsb_f(FEAT_W, N_NODES);
   localparam int LEAF_BIT   = leaf_bit_f(N_FEAT, FEAT_W, N_NODES);
   localparam logic [31:0] N_FEAT_U = 32'(N_FEAT);

   logic [FIDX_W-1:0] fidx_s;
   logic [SH_W-1:0]   shift_s;
   logic [FEAT_W-1:0] thresh_s;
   logic [FEAT_W-1:0] sel_s;
   logic [FEAT_W-1:0] shifted_s;
   logic              le_s;

   assign fidx_s    = node[FIDX_LSB +: FIDX_W];
   assign shift_s   = node[SHIFT_LSB +: SH_W];
   assign thresh_s  = node[THRESH_LSB +: FEAT_W];
   assign is_leaf   = node[LEAF_BIT];
   assign cls       = thresh_s[CLASS_W-1:0];

   // Feature select mux; an out-of-range index yields zero and is flagged via err.
   always_comb begin
      sel_s = {FEAT_W{1'b0}};
      for (int i = 0; i < N_FEAT; i++) begin
         if (fidx_s == FIDX_W'(i)) begin
            sel_s = feat[i*FEAT_W +: FEAT_W];
         end else begin
            sel_s = sel_s;
         end
      end
   end

   assign shifted_s = sel_s >> shift_s;
   assign le_s      = (shifted_s <= thresh_s);
   assign nxt       = le_s ? node[LEFT_LSB +: NIDX_W] : node[0 +: NIDX_W];
   // Zero-extend so the range check stays meaningful for non power-of-two N_FEAT.
   assign err       = !is_leaf && ({{(32-FIDX_W){1'b0}}, fidx_s} >= N_FEAT_U);
`ifdef DTREE_PATH_EN
   assign go_right  = !le_s;
`endif

endmodule

// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: programmable sequential decision-tree classifier, one node per clock.
// A node table loaded through the cfg port is walked from node 0 for each accepted
// feature vector; the leaf class (or an error) is presented on a valid/ready output.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data    node table write, honoured only while cfg_ready (IDLE)
//   in_valid/in_ready/in_feat   feature vector input handshake
//   out_valid/out_ready         result handshake
//   out_class, out_err          result class, error (depth limit or bad feature index)
//   out_path, out_depth         branch history and internal-node count (DTREE_PATH_EN only)
// Optional feature macro: DTREE_PATH_EN.
module dtree_seq_eval
   import dtree_pkg::*;
#(
   parameter int N_FEAT    = 5,
   parameter int FEAT_W    = 8,
   parameter int CLASS_W   = 5,
   parameter int N_NODES   = 16,
   parameter int MAX_DEPTH = 8,
   localparam int NIDX_W   = $clog2(N_NODES),
   localparam int NODE_W   = node_w_f(N_FEAT, FEAT_W, N_NODES),
   localparam int STEP_W   = $clog2(MAX_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [NIDX_W-1:0]        cfg_addr,
   input  logic [NODE_W-1:0]        cfg_data,
   output logic                     cfg_ready,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_FEAT*FEAT_W-1:0] in_feat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CLASS_W-1:0]       out_class,
`ifdef DTREE_PATH_EN
   output logic [MAX_DEPTH-1:0]     out_path,
   output logic [STEP_W-1:0]        out_depth,
`endif
   output logic                     out_err
);

   localparam logic [31:0] N_NODES_U   = 32'(N_NODES);
   localparam logic [31:0] MAX_DEPTH_U = 32'(MAX_DEPTH);

   logic [NODE_W-1:0]        node_tbl_r [N_NODES];
   state_t                   state_r, state_nxt;
   logic [NIDX_W-1:0]        ptr_r, ptr_nxt;
   logic [STEP_W-1:0]        step_r, step_nxt;
   logic [N_FEAT*FEAT_W-1:0] feat_r, feat_nxt;
   logic [CLASS_W-1:0]       cls_r, cls_nxt;
   logic                     err_r, err_nxt;
   logic                     out_valid_r, in_ready_r, cfg_ready_r;
   logic [NODE_W-1:0]        node_s;
   logic                     is_leaf_s, node_err_s, ptr_oob_s, step_last_s;
   logic [NIDX_W-1:0]        nxt_s;
   logic [CLASS_W-1:0]       node_cls_s;
`ifdef DTREE_PATH_EN
   logic                     go_right_s;
   logic [MAX_DEPTH-1:0]     path_r, path_nxt;
`endif

   assign node_s      = node_tbl_r[ptr_r];
   // A child index past the table end only becomes visible once it is the pointer.
   assign ptr_oob_s   = ({{(32-NIDX_W){1'b0}}, ptr_r} >= N_NODES_U);
   assign step_last_s = (({{(32-STEP_W){1'b0}}, step_r} + 32'd1) >= MAX_DEPTH_U);

   dtree_node_cmp #(
      .N_FEAT  (N_FEAT),
      .FEAT_W  (FEAT_W),
      .CLASS_W (CLASS_W),
      .N_NODES (N_NODES)
   ) u_cmp (
      .feat     (feat_r),
      .node     (node_s),
      .is_leaf  (is_leaf_s),
      .nxt      (nxt_s),
      .cls      (node_cls_s),
`ifdef DTREE_PATH_EN
      .go_right (go_right_s),
`endif
      .err      (node_err_s)
   );

   // Node table write port; the table has no reset so its contents survive rst.
   always_ff @(posedge clk) begin
      if (cfg_we && (state_r == ST_IDLE)) begin
         node_tbl_r[cfg_addr] <= cfg_data;
      end
   end

   // Walk FSM next-state and datapath update.
   always_comb begin
      state_nxt = state_r;
      ptr_nxt   = ptr_r;
      step_nxt  = step_r;
      feat_nxt  = feat_r;
      cls_nxt   = cls_r;
      err_nxt   = err_r;
`ifdef DTREE_PATH_EN
      path_nxt  = path_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               feat_nxt  = in_feat;
               ptr_nxt   = {NIDX_W{1'b0}};
               step_nxt  = {STEP_W{1'b0}};
`ifdef DTREE_PATH_EN
               path_nxt  = {MAX_DEPTH{1'b0}};
`endif
               state_nxt = ST_WALK;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WALK: begin
            if (ptr_oob_s || (!is_leaf_s && (node_err_s || step_last_s))) begin
               cls_nxt   = {CLASS_W{1'b0}};
               err_nxt   = 1'b1;
               state_nxt = ST_DONE;
            end else if (is_leaf_s) begin
               cls_nxt   = node_cls_s;
               err_nxt   = 1'b0;
               state_nxt = ST_DONE;
            end else begin
               ptr_nxt   = nxt_s;
               step_nxt  = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
`ifdef DTREE_PATH_EN
               path_nxt  = path_r | ({{(MAX_DEPTH-1){1'b0}}, go_right_s} << step_r);
`endif
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= {NIDX_W{1'b0}};
         step_r      <= {STEP_W{1'b0}};
         feat_r      <= {(N_FEAT*FEAT_W){1'b0}};
         cls_r       <= {CLASS_W{1'b0}};
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         cfg_ready_r <= 1'b1;
`ifdef DTREE_PATH_EN
         path_r      <= {MAX_DEPTH{1'b0}};
`endif
      end else begin
         state_r     <= state_nxt;
         ptr_r       <= ptr_nxt;
         step_r      <= step_nxt;
         feat_r      <= feat_nxt;
         cls_r       <= cls_nxt;
         err_r       <= err_nxt;
         out_valid_r <= (state_nxt == ST_DONE);
         in_ready_r  <= (state_nxt == ST_IDLE);
         cfg_ready_r <= (state_nxt == ST_IDLE);
`ifdef DTREE_PATH_EN
         path_r      <= path_nxt;
`endif
      end
   end

   assign out_valid = out_valid_r;
   assign out_class = cls_r;
   assign out_err   = err_r;
   assign in_ready  = in_ready_r;
   assign cfg_ready = cfg_ready_r;
`ifdef DTREE_PATH_EN
   assign out_path  = path_r;
   assign out_depth = step_r;
`endif

endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb_dtree_seq_eval: scoreboard bench for dtree_seq_eval at default parameters.
// Stimulus pushes the expected result (from a tree-walking reference model) into a
// queue; a negedge monitor pops and compares whenever out_valid rises.
module tb_dtree_seq_eval;
   import dtree_pkg::*;

   localparam int MD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [22:0] cfg_data;
   logic        cfg_ready;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] in_feat;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_class;
   logic        out_err;
`ifdef DTREE_PATH_EN
   logic [7:0]  out_path;
   logic [3:0]  out_depth;
`endif

   dtree_seq_eval dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_feat   (in_feat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
`ifdef DTREE_PATH_EN
      .out_path  (out_path),
      .out_depth (out_depth),
`endif
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cls;
      bit err;
      int lat;
      int acc;
      int path;
      int depth;
   } exp_t;

   exp_t        sb[$];
   logic [22:0] mtbl [16];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", nm, got, exp);
   endtask

   task automatic note_fail(input string nm);
      n_chk++;
      $display("FAIL %s: actual timeout/unexpected required event", nm);
   endtask

   // Reference model: walk the bench's copy of the table using the node rules directly.
   function automatic exp_t model(input logic [39:0] f);
      exp_t  e;
      node_t nd;
      int    p = 0;
      int    steps = 0;
      int    v;
      e = '{default: 0};
      for (int k = 0; k < 64; k++) begin
         e.lat++;
         nd = mtbl[p];
         if (nd.leaf) begin
            e.cls   = int'(nd.thresh) % 32;
            e.depth = steps;
            return e;
         end
         if (nd.fidx >= 5) begin
            e.err = 1'b1;
            return e;
         end
         v = int'(f[nd.fidx*8 +: 8]) >> nd.shift;
         steps++;
         if (steps >= MD) begin
            e.err = 1'b1;
            return e;
         end
         if (v <= int'(nd.thresh)) p = int'(nd.left);
         else begin
            p = int'(nd.right);
            e.path = e.path | (1 << (steps - 1));
         end
      end
      return e;
   endfunction

   function automatic logic [22:0] leaf(input int c);
      return make_node(1'b1, 3'd0, 3'd0, 8'(c), 4'd0, 4'd0);
   endfunction

   function automatic logic [22:0] rand_node();
      if ($urandom_range(0, 9) < 4) return leaf($urandom_range(0, 31));
      return make_node(1'b0, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                       8'($urandom), 4'($urandom), 4'($urandom));
   endfunction

   task automatic write_node(input logic [3:0] a, input logic [22:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
      mtbl[a] = d;
   endtask

   // One classification: accept, push expectation, wait for result, hold, release.
   task automatic send(input logic [39:0] f, input int hold, input bit hold_wr,
                       input bit same_wr, input logic [3:0] wa, input logic [22:0] wd);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) begin note_fail("in_ready_timeout"); return; end
      in_feat = f; in_valid = 1'b1;
      if (same_wr) begin
         cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; mtbl[wa] = wd;
      end
      @(negedge clk);
      in_valid = 1'b0; cfg_we = 1'b0;
      in_feat = {8'($urandom), 32'($urandom)};
      e = model(f); e.acc = cyc; sb.push_back(e);
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (!out_valid) begin note_fail("out_valid_timeout"); return; end
      for (int i = 0; i < hold; i++) begin
         chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
         if (hold_wr) begin
            cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
            chk("cfg_ready_in_done", {63'd0, cfg_ready}, 64'd0);
         end
         @(negedge clk);
      end
      cfg_we = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Monitor: compare each new result against the scoreboard and its hold stability.
   exp_t cur;
   bit   ov_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (sb.size() == 0) note_fail("spurious_out_valid");
            else begin
               cur = sb.pop_front();
               chk("class", 64'(out_class), 64'(cur.cls));
               chk("err", 64'(out_err), 64'(cur.err));
               chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
`ifdef DTREE_PATH_EN
               if (!cur.err) begin
                  chk("path", 64'(out_path), 64'(cur.path));
                  chk("depth", 64'(out_depth), 64'(cur.depth));
               end
`endif
            end
         end else if (out_valid) begin
            chk("hold_class", 64'(out_class), 64'(cur.cls));
            chk("hold_err", 64'(out_err), 64'(cur.err));
         end
         ov_prev = out_valid;
      end
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 23'd0;
      in_valid = 1'b0; in_feat = 40'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_class", 64'(out_class), 64'd0);
      chk("rst_out_err", {63'd0, out_err}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
`ifdef DTREE_PATH_EN
      chk("rst_out_path", 64'(out_path), 64'd0);
      chk("rst_out_depth", 64'(out_depth), 64'd0);
`endif

      write_node(4'd0, make_node(1'b0, 3'd4, 3'd6, 8'd0, 4'd1, 4'd2));
      write_node(4'd1, leaf(7));
      write_node(4'd2, make_node(1'b0, 3'd4, 3'd5, 8'd1, 4'd3, 4'd4));
      write_node(4'd3, leaf(24));
      write_node(4'd4, leaf(12));
      for (int a = 5; a < 16; a++) write_node(4'(a), leaf($urandom_range(0, 31)));

      send({8'h30, 32'($urandom)}, 0, 1'b0, 1'b0, 4'd0, 23'd0);
      send({8'h40, 32'($urandom)}, 0, 1'b0, 1'b0, 4'd0, 23'd0);
      send({8'h70, 32'($urandom)}, 0, 1'b0, 1'b0, 4'd0, 23'd0);
      // Hold in DONE while attempting a table write that must be ignored.
      send({8'h30, 32'($urandom)}, 5, 1'b1, 1'b0, 4'd1, leaf(31));
      send({8'h30, 32'($urandom)}, 0, 1'b0, 1'b0, 4'd0, 23'd0);

      // Self-loop hits the step limit.
      write_node(4'd0, make_node(1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 4'd0));
      send(40'($urandom), 1, 1'b0, 1'b0, 4'd0, 23'd0);
      // Invalid feature index one step in.
      write_node(4'd0, make_node(1'b0, 3'd0, 3'd0, 8'hFF, 4'd5, 4'd5));
      write_node(4'd5, make_node(1'b0, 3'd6, 3'd0, 8'd0, 4'd1, 4'd1));
      send(40'($urandom), 0, 1'b0, 1'b0, 4'd0, 23'd0);
      write_node(4'd0, make_node(1'b0, 3'd4, 3'd6, 8'd0, 4'd1, 4'd2));

      // Reset mid-walk: no result may appear, table must survive.
      in_feat = {8'h40, 32'd0}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
         @(negedge clk);
      end
      send({8'h40, 32'($urandom)}, 0, 1'b0, 1'b0, 4'd0, 23'd0);
      // Table write in the accept cycle is seen by that walk.
      send({8'h30, 32'($urandom)}, 0, 1'b0, 1'b1, 4'd1, leaf(9));

      for (int t = 0; t < 6; t++) begin
         for (int a = 0; a < 16; a++) write_node(4'(a), rand_node());
         for (int v = 0; v < 8; v++)
            send({8'($urandom), 32'($urandom)}, $urandom_range(0, 3), 1'b0, 1'b0, 4'd0, 23'd0);
      end

      repeat (3) @(negedge clk);
      if (sb.size() != 0) note_fail("scoreboard_not_empty");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
